// File: rtl/recorder_pkg.sv
// Shared types for the recorder control block: event decoding,
// FSM state encoding and playback speed modes.
package recorder_pkg;

    localparam int ADDR_W_DEF = 20;

    localparam int CODE_MSB   = 15;
    localparam int CODE_LSB   = 12;
    localparam int SPEED_MSB  = 11;
    localparam int SPEED_LSB  = 10;
    localparam int PARAM_MSB  = 9;
    localparam int PARAM_LSB  = 6;
    localparam int INTERP_BIT = 5;

    typedef enum logic [3:0] {
        EV_NONE   = 4'd0,
        EV_PLAY   = 4'd1,
        EV_PAUSE  = 4'd2,
        EV_STOP   = 4'd3,
        EV_RECORD = 4'd4,
        EV_SPEED  = 4'd5
    } ev_code_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PLAY       = 3'd1,
        ST_PAUSE_PLAY = 3'd2,
        ST_RECORD     = 3'd3,
        ST_PAUSE_REC  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SP_NORMAL = 2'd0,
        SP_FAST   = 2'd1,
        SP_SLOW   = 2'd2,
        SP_RSVD   = 2'd3
    } speed_e;

endpackage

// File: rtl/recorder_ctrl_stepper.sv
// Playback pointer advance: computes the next pointer/phase for one
// sample tick and flags when the advance reaches the recorded end.
module recorder_ctrl_stepper
    import recorder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] i_ptr,
    input  logic [2:0]        i_phase,
    input  speed_e            i_mode,
    input  logic [3:0]        i_factor,
    input  logic [ADDR_W-1:0] i_end,
    output logic [ADDR_W-1:0] o_next_ptr,
    output logic [2:0]        o_next_phase,
    output logic              o_end_hit
);

    localparam int SW = ADDR_W + 1;

    logic [ADDR_W:0] w_inc;
    logic [ADDR_W:0] w_sum;

    always_comb begin
        w_inc        = '0;
        o_next_phase = '0;
        unique case (i_mode)
            SP_FAST: w_inc = SW'(i_factor);
            SP_SLOW: begin
                if ({1'b0, i_phase} == i_factor - 4'd1)
                    w_inc = SW'(1);
                else
                    o_next_phase = i_phase + 3'd1;
            end
            default: w_inc = SW'(1);
        endcase
        // One bit wider than the address so a wrap still counts as past the end
        w_sum = {1'b0, i_ptr} + w_inc;
    end

    assign o_next_ptr = w_sum[ADDR_W-1:0];
    assign o_end_hit  = w_sum >= {1'b0, i_end};

endmodule

// File: rtl/recorder_ctrl.sv
// Recorder transport FSM: record/play/pause/stop, SRAM pointer,
// recorded length and per-sample memory requests.
module recorder_ctrl
    import recorder_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_ADDR = 2**ADDR_W - 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [15:0]       i_input_event,
    input  logic              i_sample_tick,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_rec_req,
    output logic              o_play_req,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic [1:0]        o_speed_mode,
    output logic [3:0]        o_speed_factor,
    output logic [2:0]        o_slow_phase,
    output logic              o_interpol,
    output logic              o_done,
    output logic              o_full
);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_end;
    logic [2:0]        r_phase;
    logic [2:0]        r_slow_phase;
    logic [2:0]        r_param;
    speed_e            r_mode;
    logic              r_interp;
    logic              r_rec_req;
    logic              r_play_req;
    logic              r_done;
    logic              r_full;

    logic [3:0]        w_code;
    speed_e            w_speed;
    logic [2:0]        w_param;
    logic              w_interp;
    logic              w_evt;
    logic              w_ev_play;
    logic              w_ev_pause;
    logic              w_ev_stop;
    logic              w_ev_rec;
    logic              w_tick;
    logic              w_max;
    logic [3:0]        w_factor;
    logic [3:0]        w_new_factor;
    logic [ADDR_W-1:0] w_next_ptr;
    logic [2:0]        w_next_phase;
    logic              w_end_hit;
    logic              w_unused_bits;

    assign w_code   = i_input_event[CODE_MSB:CODE_LSB];
    assign w_speed  = speed_e'(i_input_event[SPEED_MSB:SPEED_LSB]);
    assign w_param  = i_input_event[PARAM_LSB+2:PARAM_LSB];
    assign w_interp = i_input_event[INTERP_BIT];
    assign w_unused_bits = ^{i_input_event[PARAM_MSB], i_input_event[4:0]};

    assign w_evt      = (w_code >= EV_PLAY) && (w_code <= EV_SPEED);
    assign w_ev_play  = w_code == EV_PLAY;
    assign w_ev_pause = w_code == EV_PAUSE;
    assign w_ev_stop  = w_code == EV_STOP;
    assign w_ev_rec   = w_code == EV_RECORD;

    // An event wins over a coincident tick; back-to-back requests are blocked
    assign w_tick = i_sample_tick & ~w_evt & ~r_rec_req & ~r_play_req;

    assign w_factor     = {1'b0, r_param} + 4'd1;
    assign w_new_factor = {1'b0, w_param} + 4'd1;
    assign w_max        = r_ptr == ADDR_W'(MAX_ADDR);

    recorder_ctrl_stepper #(
        .ADDR_W (ADDR_W)
    ) u_stepper (
        .i_ptr        (r_ptr),
        .i_phase      (r_phase),
        .i_mode       (r_mode),
        .i_factor     (w_factor),
        .i_end        (r_end),
        .o_next_ptr   (w_next_ptr),
        .o_next_phase (w_next_phase),
        .o_end_hit    (w_end_hit)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ev_play && r_end != '0)
                    w_next_state = ST_PLAY;
                else if (w_ev_rec)
                    w_next_state = ST_RECORD;
            end
            ST_PLAY: begin
                if (w_ev_pause)
                    w_next_state = ST_PAUSE_PLAY;
                else if (w_ev_stop)
                    w_next_state = ST_IDLE;
                else if (w_tick && w_end_hit)
                    w_next_state = ST_IDLE;
            end
            ST_PAUSE_PLAY: begin
                if (w_ev_play)
                    w_next_state = ST_PLAY;
                else if (w_ev_stop)
                    w_next_state = ST_IDLE;
            end
            ST_RECORD: begin
                if (w_ev_pause)
                    w_next_state = ST_PAUSE_REC;
                else if (w_ev_stop)
                    w_next_state = ST_IDLE;
                else if (w_tick && w_max)
                    w_next_state = ST_IDLE;
            end
            ST_PAUSE_REC: begin
                if (w_ev_rec)
                    w_next_state = ST_RECORD;
                else if (w_ev_stop)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_state        = r_state;
        o_mem_addr     = r_addr;
        o_rec_req      = r_rec_req;
        o_play_req     = r_play_req;
        o_end_addr     = r_end;
        o_speed_mode   = r_mode;
        o_speed_factor = w_factor;
        o_slow_phase   = r_slow_phase;
        o_interpol     = r_interp;
        o_done         = r_done;
        o_full         = r_full;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ptr        <= '0;
            r_addr       <= '0;
            r_end        <= '0;
            r_phase      <= '0;
            r_slow_phase <= '0;
            r_param      <= '0;
            r_mode       <= SP_NORMAL;
            r_interp     <= 1'b0;
            r_rec_req    <= 1'b0;
            r_play_req   <= 1'b0;
            r_done       <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            r_rec_req  <= 1'b0;
            r_play_req <= 1'b0;
            r_done     <= 1'b0;
            r_full     <= 1'b0;
            if (w_evt) begin
                r_mode   <= w_speed;
                r_param  <= w_param;
                r_interp <= w_interp;
                if ({1'b0, r_phase} >= w_new_factor)
                    r_phase <= '0;
                if (w_ev_stop || (r_state == ST_IDLE && w_ev_play)) begin
                    r_ptr   <= '0;
                    r_phase <= '0;
                end
                if (r_state == ST_IDLE && w_ev_rec) begin
                    r_ptr <= '0;
                    r_end <= '0;
                end
            end else if (w_tick) begin
                if (r_state == ST_RECORD) begin
                    r_rec_req <= 1'b1;
                    r_addr    <= r_ptr;
                    r_end     <= r_ptr + 1'b1;
                    if (w_max) begin
                        r_full <= 1'b1;
                        r_ptr  <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end else if (r_state == ST_PLAY) begin
                    r_play_req   <= 1'b1;
                    r_addr       <= r_ptr;
                    r_slow_phase <= r_phase;
                    if (w_end_hit) begin
                        r_done  <= 1'b1;
                        r_ptr   <= '0;
                        r_phase <= '0;
                    end else begin
                        r_ptr   <= w_next_ptr;
                        r_phase <= w_next_phase;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_recorder_ctrl.sv
// Directed bench for recorder_ctrl with a cycle-level reference model
// and literal checks on the request address sequences.
`timescale 1ns/1ps
module tb_recorder_ctrl;
    import recorder_pkg::*;

    localparam int AW   = 4;
    localparam int MAXA = (1 << AW) - 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   ev    = '0;
    logic          tick  = 1'b0;
    logic [2:0]    o_state;
    logic [AW-1:0] o_mem_addr;
    logic          o_rec_req;
    logic          o_play_req;
    logic [AW-1:0] o_end_addr;
    logic [1:0]    o_speed_mode;
    logic [3:0]    o_speed_factor;
    logic [2:0]    o_slow_phase;
    logic          o_interpol;
    logic          o_done;
    logic          o_full;

    recorder_ctrl #(.ADDR_W(AW)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_input_event  (ev),
        .i_sample_tick  (tick),
        .o_state        (o_state),
        .o_mem_addr     (o_mem_addr),
        .o_rec_req      (o_rec_req),
        .o_play_req     (o_play_req),
        .o_end_addr     (o_end_addr),
        .o_speed_mode   (o_speed_mode),
        .o_speed_factor (o_speed_factor),
        .o_slow_phase   (o_slow_phase),
        .o_interpol     (o_interpol),
        .o_done         (o_done),
        .o_full         (o_full)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string nm, input int q[$], input int e[$]);
        chk({nm, "_len"}, q.size(), e.size());
        for (int i = 0; i < e.size() && i < q.size(); i++)
            chk($sformatf("%s[%0d]", nm, i), q[i], e[i]);
    endtask

    // Reference model: sample-level transport behaviour in plain integers
    int e_st, e_addr, e_rec, e_play, e_end, e_mode, e_fac;
    int e_sph, e_int, e_done, e_full;
    int m_ptr, m_ph, code;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            e_st = ST_IDLE; e_addr = 0; e_rec = 0; e_play = 0; e_end = 0;
            e_mode = 0; e_fac = 1; e_sph = 0; e_int = 0;
            e_done = 0; e_full = 0; m_ptr = 0; m_ph = 0;
        end else begin
            code = int'(ev[15:12]);
            e_rec = 0; e_play = 0; e_done = 0; e_full = 0;
            if (code >= 1 && code <= 5) begin
                e_mode = int'(ev[11:10]);
                e_fac  = int'(ev[8:6]) + 1;
                e_int  = int'(ev[5]);
                if (m_ph >= e_fac) m_ph = 0;
                case (code)
                    1: if (e_st == ST_IDLE && e_end != 0) begin
                           e_st = ST_PLAY; m_ptr = 0; m_ph = 0;
                       end else if (e_st == ST_PAUSE_PLAY) e_st = ST_PLAY;
                    2: if (e_st == ST_PLAY) e_st = ST_PAUSE_PLAY;
                       else if (e_st == ST_RECORD) e_st = ST_PAUSE_REC;
                    3: begin e_st = ST_IDLE; m_ptr = 0; m_ph = 0; end
                    4: if (e_st == ST_IDLE) begin
                           e_st = ST_RECORD; m_ptr = 0; e_end = 0;
                       end else if (e_st == ST_PAUSE_REC) e_st = ST_RECORD;
                    default: ;
                endcase
            end else if (tick) begin
                if (e_st == ST_RECORD) begin
                    e_rec = 1; e_addr = m_ptr;
                    m_ptr++;
                    e_end = m_ptr % (MAXA + 1);
                    if (m_ptr > MAXA) begin
                        e_full = 1; e_st = ST_IDLE; m_ptr = 0;
                    end
                end else if (e_st == ST_PLAY) begin
                    e_play = 1; e_addr = m_ptr; e_sph = m_ph;
                    if (e_mode == 1) begin
                        m_ptr += e_fac; m_ph = 0;
                    end else if (e_mode == 2) begin
                        m_ph++;
                        if (m_ph == e_fac) begin m_ph = 0; m_ptr++; end
                    end else begin
                        m_ptr++; m_ph = 0;
                    end
                    if (m_ptr >= e_end) begin
                        e_done = 1; e_st = ST_IDLE; m_ptr = 0; m_ph = 0;
                    end
                end
            end
        end
    end

    int rec_q[$];
    int play_q[$];
    int ph_q[$];
    int done_n = 0;
    int full_n = 0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("state",   int'(o_state),        e_st);
            chk("addr",    int'(o_mem_addr),     e_addr);
            chk("rec_req", int'(o_rec_req),      e_rec);
            chk("play_req",int'(o_play_req),     e_play);
            chk("end",     int'(o_end_addr),     e_end);
            chk("mode",    int'(o_speed_mode),   e_mode);
            chk("factor",  int'(o_speed_factor), e_fac);
            chk("phase",   int'(o_slow_phase),   e_sph);
            chk("interp",  int'(o_interpol),     e_int);
            chk("done",    int'(o_done),         e_done);
            chk("full",    int'(o_full),         e_full);
            if (o_rec_req) rec_q.push_back(int'(o_mem_addr));
            if (o_play_req) begin
                play_q.push_back(int'(o_mem_addr));
                ph_q.push_back(int'(o_slow_phase));
            end
            if (o_done) done_n++;
            if (o_full) full_n++;
        end
    end

    function automatic logic [15:0] evw(input int c, input int sp,
                                        input int pr, input int it);
        logic [3:0] c4  = c[3:0];
        logic [1:0] s2  = sp[1:0];
        logic [3:0] p4  = pr[3:0];
        logic       i1  = it[0];
        return {c4, s2, p4, i1, 5'b0};
    endfunction

    task automatic send(input int c, input int sp, input int pr, input int it);
        @(negedge clk);
        ev = evw(c, sp, pr, it);
        @(negedge clk);
        ev = '0;
    endtask

    task automatic tk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic clr();
        rec_q.delete(); play_q.delete(); ph_q.delete();
        done_n = 0; full_n = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_state",  int'(o_state), int'(ST_IDLE));
        chk("rst_factor", int'(o_speed_factor), 1);
        chk("rst_end",    int'(o_end_addr), 0);
        rst_n = 1'b1;

        // record 5 samples, then play them back
        clr();
        send(4, 0, 0, 0);
        tk(5);
        send(3, 0, 0, 0);
        @(negedge clk);
        chk_log("rec5", rec_q, '{0, 1, 2, 3, 4});
        chk("rec5_end",   int'(o_end_addr), 5);
        chk("rec5_state", int'(o_state), int'(ST_IDLE));
        clr();
        send(1, 0, 0, 0);
        tk(5);
        chk_log("play5", play_q, '{0, 1, 2, 3, 4});
        chk("play5_done",  done_n, 1);
        chk("play5_state", int'(o_state), int'(ST_IDLE));

        // 10-sample take, fast play x3
        send(4, 0, 0, 0);
        tk(10);
        send(3, 0, 0, 0);
        chk("rec10_end", int'(o_end_addr), 10);
        clr();
        send(1, 1, 2, 0);
        tk(5);
        chk_log("fast", play_q, '{0, 3, 6, 9});
        chk("fast_done", done_n, 1);

        // slow play /2 with interpolation
        clr();
        send(5, 2, 1, 1);
        chk("speed_state", int'(o_state), int'(ST_IDLE));
        send(1, 2, 1, 1);
        tk(5);
        chk_log("slow_addr",  play_q, '{0, 0, 1, 1, 2});
        chk_log("slow_phase", ph_q,   '{0, 1, 0, 1, 0});
        chk("slow_interp", int'(o_interpol), 1);
        send(3, 0, 0, 0);

        // pause colliding with a tick, then resume
        clr();
        send(1, 0, 0, 0);
        tk(4);
        @(negedge clk);
        ev = evw(2, 0, 0, 0);
        tick = 1'b1;
        @(negedge clk);
        ev = '0;
        tick = 1'b0;
        tk(1);
        chk("pause_state", int'(o_state), int'(ST_PAUSE_PLAY));
        send(1, 0, 0, 0);
        tk(1);
        chk_log("pause", play_q, '{0, 1, 2, 3, 4});
        send(3, 0, 0, 0);

        // async reset in the middle of a recording
        clr();
        send(4, 0, 0, 0);
        tk(7);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",   int'(o_rec_req), 0);
        chk("arst_state", int'(o_state), int'(ST_IDLE));
        chk("arst_end",   int'(o_end_addr), 0);
        chk("arst_addr",  int'(o_mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fill the whole address space
        clr();
        send(4, 0, 0, 0);
        tk(16);
        chk("full_n",     full_n, 1);
        chk("full_len",   rec_q.size(), 16);
        if (rec_q.size() == 16)
            chk("full_last", rec_q[15], 15);
        chk("full_state", int'(o_state), int'(ST_IDLE));
        chk("full_end",   int'(o_end_addr), 0);
        tk(1);
        chk("full_17th",  rec_q.size(), 16);

        // play with nothing recorded
        clr();
        send(1, 0, 0, 0);
        tk(2);
        chk("empty_state", int'(o_state), int'(ST_IDLE));
        chk("empty_reqs",  play_q.size(), 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
